// File: rtl/scoreboard_stim_driver.sv
// Legal push/pop traffic generator that designates one magic packet and predicts its exit cycle.
// Optional random request thinning is enabled by defining SSD_LFSR_EN.
module scoreboard_stim_driver #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNTWID = $clog2(DEPTH) + 1,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic              start_req,
    output logic              push,
    output logic              pop,
    output logic              start,
    output logic [WIDTH-1:0]  data_in,
    output logic [CNTWID-1:0] occupancy,
    output logic [WIDTH-1:0]  magic_value,
    output logic              exp_exit,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StArmed, StTracking, StDone} state_e;

    state_e            state_q, state_d;
    logic              push_q, pop_q, start_q, exp_exit_q, done_q;
    logic              push_d, pop_d, start_d, exp_exit_d;
    logic [WIDTH-1:0]  data_q, data_d, magic_q, magic_d, dcnt_q, dcnt_d;
    logic [CNTWID-1:0] cnt_q, ahead_q, ahead_d, cnt_after;
    logic              gate_p, gate_q;

`ifdef SSD_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign gate_p = lfsr_q[0];
    assign gate_q = lfsr_q[1];
`else
    assign gate_p = 1'b1;
    assign gate_q = 1'b1;
`endif

    always_comb begin
        // Occupancy once the pushes/pops currently on the outputs have landed.
        cnt_after  = cnt_q + CNTWID'(push_q) - CNTWID'(pop_q);
        push_d     = push_req & gate_p & (cnt_after != CNTWID'(DEPTH));
        pop_d      = pop_req & gate_q & (cnt_after != '0);
        state_d    = state_q;
        start_d    = 1'b0;
        exp_exit_d = 1'b0;
        ahead_d    = ahead_q;
        magic_d    = magic_q;
        data_d     = push_d ? dcnt_q : data_q;
        dcnt_d     = push_d ? dcnt_q + WIDTH'(1) : dcnt_q;

        case (state_q)
            StIdle: begin
                if (start_req) state_d = StArmed;
            end
            StArmed: begin
                if (push_d) begin
                    start_d = 1'b1;
                    magic_d = dcnt_q;
                    // A pop issued alongside the magic push removes an older packet.
                    ahead_d = cnt_after - CNTWID'(pop_d);
                    state_d = StTracking;
                end
            end
            StTracking: begin
                if (pop_d) begin
                    if (ahead_q == '0) begin
                        exp_exit_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        ahead_d = ahead_q - CNTWID'(1);
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            start_q    <= 1'b0;
            exp_exit_q <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            magic_q    <= '0;
            dcnt_q     <= '0;
            cnt_q      <= '0;
            ahead_q    <= '0;
        end else begin
            state_q    <= state_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            start_q    <= start_d;
            exp_exit_q <= exp_exit_d;
            done_q     <= (state_q == StDone);
            data_q     <= data_d;
            magic_q    <= magic_d;
            dcnt_q     <= dcnt_d;
            cnt_q      <= cnt_after;
            ahead_q    <= ahead_d;
        end
    end

    assign push        = push_q;
    assign pop         = pop_q;
    assign start       = start_q;
    assign data_in     = data_q;
    assign magic_value = magic_q;
    assign exp_exit    = exp_exit_q;
    assign done        = done_q;
    assign occupancy   = cnt_after;

endmodule
